// File: rtl/corectrl.sv
// Decoded instruction control bundle and helpers used by the execution units,
// including the funct3 access-size encodings for loads and stores.
package corectrl;
  typedef enum logic [2:0] {
    IT_X, IT_R, IT_I, IT_S, IT_B, IT_U, IT_J
  } InstType;

  typedef struct packed {
    InstType    itype;
    logic       is_load;
    logic [2:0] funct3;
  } InstCtrl;

  // funct3[1:0] selects the access size; funct3[2] marks a zero-extending load
  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;
  localparam logic [1:0] MEM_D = 2'b11;
  localparam int FUNCT3_UNSIGNED_BIT = 2;

  function automatic logic inst_is_memop(input InstCtrl c);
    return (c.itype == IT_S) || c.is_load;
  endfunction

  function automatic logic inst_is_store(input InstCtrl c);
    return c.itype == IT_S;
  endfunction
endpackage

// File: rtl/eei.sv
// Execution-environment constants shared across the core: register and
// memory bus widths.
package eei;
  localparam int XLEN           = 64;
  localparam int MEM_DATA_WIDTH = 64;
  localparam int MEM_MASK_WIDTH = MEM_DATA_WIDTH / 8;
endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane alignment: store mask/data shifting and load
// extract/extend. Offset bits below the access size are ignored.
module mem_align
  import corectrl::*;
#(
  parameter int XLEN           = 64,
  parameter int MEM_DATA_WIDTH = 64,
  localparam int MASK_W        = MEM_DATA_WIDTH / 8,
  localparam int OFF_W         = $clog2(MASK_W)
) (
  input  logic [1:0]                st_size,
  input  logic [OFF_W-1:0]          st_off,
  input  logic [XLEN-1:0]           st_data,
  output logic [MASK_W-1:0]         wmask,
  output logic [MEM_DATA_WIDTH-1:0] wdata,
  input  logic [2:0]                ld_funct3,
  input  logic [OFF_W-1:0]          ld_off,
  input  logic [MEM_DATA_WIDTH-1:0] ld_data,
  output logic [XLEN-1:0]           rdata
);
  function automatic logic [OFF_W-1:0] align_off(input logic [1:0] size,
                                                 input logic [OFF_W-1:0] off);
    case (size)
      MEM_B:   return off;
      MEM_H:   return {off[OFF_W-1:1], 1'b0};
      MEM_W:   return {off[OFF_W-1:2], 2'b00};
      default: return '0;
    endcase
  endfunction

  logic [OFF_W-1:0]          st_a;
  logic [OFF_W-1:0]          ld_a;
  logic [MASK_W-1:0]         base_mask;
  logic [MEM_DATA_WIDTH-1:0] sh;
  logic                      sext;

  always_comb begin
    st_a = align_off(st_size, st_off);
    case (st_size)
      MEM_B:   base_mask = MASK_W'(1);
      MEM_H:   base_mask = MASK_W'(3);
      MEM_W:   base_mask = MASK_W'(15);
      default: base_mask = '1;
    endcase
    wmask = base_mask << st_a;
    wdata = MEM_DATA_WIDTH'(st_data) << {st_a, 3'b000};
  end

  always_comb begin
    ld_a = align_off(ld_funct3[1:0], ld_off);
    sh   = ld_data >> {ld_a, 3'b000};
    sext = ~ld_funct3[FUNCT3_UNSIGNED_BIT];
    case (ld_funct3[1:0])
      MEM_B:   rdata = {{(XLEN-8){sext & sh[7]}}, sh[7:0]};
      MEM_H:   rdata = {{(XLEN-16){sext & sh[15]}}, sh[15:0]};
      MEM_W:   rdata = {{(XLEN-32){sext & sh[31]}}, sh[31:0]};
      default: rdata = sh[XLEN-1:0];
    endcase
  end
endmodule

// File: rtl/memunit.sv
// MEM-stage load/store unit: issues one data-memory transaction per memop and
// stalls until it completes. Optional MEMUNIT_MISALIGN_CHECK_EN adds misaligned.
module memunit
  import corectrl::*;
#(
  parameter int XLEN           = eei::XLEN,
  parameter int MEM_DATA_WIDTH = eei::MEM_DATA_WIDTH,
  localparam int MASK_W        = MEM_DATA_WIDTH / 8,
  localparam int OFF_W         = $clog2(MASK_W)
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef MEMUNIT_MISALIGN_CHECK_EN
  output logic                      misaligned,
`endif
  input  logic                      valid,
  input  logic                      is_new,
  input  InstCtrl                   ctrl,
  input  logic [XLEN-1:0]           addr,
  input  logic [XLEN-1:0]           rs2,
  output logic [XLEN-1:0]           rdata,
  output logic                      stall,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [XLEN-1:0]           mem_addr,
  output logic                      mem_wen,
  output logic [MEM_DATA_WIDTH-1:0] mem_wdata,
  output logic [MASK_W-1:0]         mem_wmask,
  input  logic                      mem_rvalid,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, WAIT_READY, WAIT_VALID} MemState;

  MemState                   state, state_next;
  logic                      memop, is_store, issue_req, issue;
  logic [2:0]                funct3_q;
  logic [OFF_W-1:0]          off_q;
  logic [MASK_W-1:0]         wmask_n;
  logic [MEM_DATA_WIDTH-1:0] wdata_n;

  assign memop     = inst_is_memop(ctrl);
  assign is_store  = inst_is_store(ctrl);
  assign issue_req = (state == IDLE) && valid && is_new && memop;

`ifdef MEMUNIT_MISALIGN_CHECK_EN
  logic [OFF_W-1:0] low_mask;
  logic             bad_align;

  always_comb begin
    case (ctrl.funct3[1:0])
      MEM_B:   low_mask = '0;
      MEM_H:   low_mask = OFF_W'(1);
      MEM_W:   low_mask = OFF_W'(3);
      default: low_mask = OFF_W'(7);
    endcase
    bad_align = (addr[OFF_W-1:0] & low_mask) != '0;
  end

  // A misaligned memop is reported and dropped without touching the bus
  assign issue      = issue_req && !bad_align;
  assign misaligned = issue_req && bad_align;
`else
  assign issue = issue_req;
`endif

  mem_align #(.XLEN(XLEN), .MEM_DATA_WIDTH(MEM_DATA_WIDTH)) u_align (
    .st_size   (ctrl.funct3[1:0]),
    .st_off    (addr[OFF_W-1:0]),
    .st_data   (rs2),
    .wmask     (wmask_n),
    .wdata     (wdata_n),
    .ld_funct3 (funct3_q),
    .ld_off    (off_q),
    .ld_data   (mem_rdata),
    .rdata     (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      funct3_q  <= '0;
      off_q     <= '0;
    end else begin
      state <= state_next;
      if (issue) begin
        mem_addr  <= {addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
        mem_wen   <= is_store;
        mem_wdata <= wdata_n;
        mem_wmask <= wmask_n;
        funct3_q  <= ctrl.funct3;
        off_q     <= addr[OFF_W-1:0];
      end
    end
  end

  // Handshake: request holds while mem_valid && !mem_ready; the response is
  // the single cycle with mem_rvalid in WAIT_VALID, which also ends the stall.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    mem_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          state_next = WAIT_READY;
          stall      = 1'b1;
        end
      end
      WAIT_READY: begin
        mem_valid = 1'b1;
        stall     = 1'b1;
        if (mem_ready) state_next = WAIT_VALID;
      end
      WAIT_VALID: begin
        if (mem_rvalid) state_next = IDLE;
        else            stall      = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_memunit.sv
// Self-checking bench for memunit: directed cases plus randomized memops
// checked against a byte-lane reference model. Honours MEMUNIT_MISALIGN_CHECK_EN.
module tb_memunit;
  import corectrl::*;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid = 1'b0;
  logic          is_new = 1'b0;
  InstCtrl       ctrl = '0;
  logic [63:0]   addr = '0, rs2 = '0, rdata, mem_addr, mem_wdata;
  logic [63:0]   mem_rdata = '0;
  logic          stall, mem_valid, mem_wen;
  logic          mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [7:0]    mem_wmask;
`ifdef MEMUNIT_MISALIGN_CHECK_EN
  logic          misaligned;
`endif
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  memunit dut (
    .clk(clk), .rst(rst),
`ifdef MEMUNIT_MISALIGN_CHECK_EN
    .misaligned(misaligned),
`endif
    .valid(valid), .is_new(is_new), .ctrl(ctrl), .addr(addr), .rs2(rs2),
    .rdata(rdata), .stall(stall), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: byte-lane arithmetic on the access size and offset
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic int aoff(input logic [2:0] f3, input logic [63:0] a);
    int off;
    off = int'(a[2:0]);
    return (off / nbytes(f3)) * nbytes(f3);
  endfunction

  function automatic logic [7:0] exp_mask(input logic [2:0] f3, input logic [63:0] a);
    logic [15:0] m;
    m = (16'd1 << nbytes(f3)) - 16'd1;
    return 8'(m << aoff(f3, a));
  endfunction

  function automatic logic [63:0] exp_wdata(input logic [2:0] f3, input logic [63:0] a,
                                            input logic [63:0] d);
    return d << (8 * aoff(f3, a));
  endfunction

  function automatic logic [63:0] exp_load(input logic [2:0] f3, input logic [63:0] a,
                                           input logic [63:0] md);
    logic [63:0] r;
    int n, o;
    n = nbytes(f3);
    o = aoff(f3, a);
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = md[8*(o+i) +: 8];
    if (!f3[2] && n < 8 && r[8*n-1]) r = r | ~((64'd1 << (8*n)) - 64'd1);
    return r;
  endfunction

  task automatic drive_issue(input logic ld, input logic [2:0] f3, input logic [63:0] a,
                             input logic [63:0] d);
    valid = 1'b1; is_new = 1'b1;
    ctrl.itype = ld ? IT_I : IT_S; ctrl.is_load = ld; ctrl.funct3 = f3;
    addr = a; rs2 = d; mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic do_memop(input logic ld, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] d, input logic [63:0] rd, input int rdly,
                          input int vdly, output logic [63:0] got_r);
    logic [63:0] e_addr;
    int nst;
    e_addr = a & ~64'h7;
    nst = 0;
    got_r = '0;
    tick();
    drive_issue(ld, f3, a, d);
    #1;
    check("issue_stall", stall, 1);
    check("issue_mem_valid", mem_valid, 0);
    nst += int'(stall);
    for (int k = 0; k <= rdly; k++) begin
      tick();
      is_new = 1'b0;
      mem_ready = (k == rdly);
      mem_rvalid = (k == rdly) ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      check("req_mem_valid", mem_valid, 1);
      check("req_addr", mem_addr, e_addr);
      check("req_wen", mem_wen, !ld);
      if (!ld) begin
        check("req_wmask", mem_wmask, exp_mask(f3, a));
        check("req_wdata", mem_wdata, exp_wdata(f3, a, d));
      end
      nst += int'(stall);
    end
    for (int j = 0; j <= vdly; j++) begin
      tick();
      mem_ready = 1'b0;
      mem_rvalid = (j == vdly);
      mem_rdata = (j == vdly) ? rd : {$urandom, $urandom};
      #1;
      check("resp_mem_valid", mem_valid, 0);
      nst += int'(stall);
      if (j == vdly) begin
        got_r = rdata;
        if (ld) check("load_rdata", rdata, exp_load(f3, a, rd));
      end
    end
    tick();
    mem_rvalid = 1'b0;
    #1;
    check("done_stall", stall, 0);
    check("done_mem_valid", mem_valid, 0);
    tick();
    #1;
    check("no_reissue_valid", mem_valid, 0);
    check("no_reissue_stall", stall, 0);
    valid = 1'b0;
    check("stall_cycles", 64'(nst), 64'(2 + rdly + vdly));
  endtask

`ifdef MEMUNIT_MISALIGN_CHECK_EN
  task automatic do_mis(input logic ld, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] d);
    tick();
    drive_issue(ld, f3, a, d);
    #1;
    check("mis_pulse", misaligned, 1);
    check("mis_stall", stall, 0);
    check("mis_mem_valid", mem_valid, 0);
    tick();
    is_new = 1'b0;
    #1;
    check("mis_pulse_end", misaligned, 0);
    check("mis_no_req", mem_valid, 0);
    check("mis_no_stall", stall, 0);
    valid = 1'b0;
  endtask
`endif

  initial begin
    logic [63:0] r, a, d, md;
    logic [2:0]  f3;
    logic        ld;

    // reset state
    tick();
    tick();
    check("rst_stall", stall, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_wen", mem_wen, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wmask", 64'(mem_wmask), 0);
    check("rst_rdata", rdata, 0);
    rst = 1'b1;

    // SD, ready one cycle late: three stall cycles
    do_memop(1'b0, 3'b011, 64'h1000, 64'h1122334455667788, 64'h0, 1, 0, r);
    // SB at byte 3
    do_memop(1'b0, 3'b000, 64'h1003, 64'hAB, 64'h0, 0, 0, r);
    check("sb_lane", 64'(mem_wdata[31:24]), 64'hAB);
    check("sb_mask", 64'(mem_wmask), 64'h08);
    // LB / LBU at byte 5
    do_memop(1'b1, 3'b000, 64'h2005, 64'h0, 64'h0000_80FF_0000_0000, 0, 1, r);
    check("lb_value", r, 64'hFFFF_FFFF_FFFF_FF80);
    do_memop(1'b1, 3'b100, 64'h2005, 64'h0, 64'h0000_80FF_0000_0000, 0, 0, r);
    check("lbu_value", r, 64'h80);
    // ready held off for 5 cycles
    do_memop(1'b1, 3'b010, 64'h2008, 64'h0, 64'h0123_4567_89AB_CDEF, 5, 2, r);
    check("lw_value", r, 64'hFFFF_FFFF_89AB_CDEF);

    // reset while waiting for the response, then a stray rvalid
    tick();
    drive_issue(1'b0, 3'b011, 64'h4008, 64'hDEAD_BEEF_CAFE_F00D);
    tick();
    is_new = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    check("pre_rst_stall", stall, 1);
    check("pre_rst_wen", mem_wen, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = '0;
    #1;
    check("mid_rst_mem_valid", mem_valid, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_wen", mem_wen, 0);
    check("mid_rst_wdata", mem_wdata, 0);
    check("mid_rst_wmask", 64'(mem_wmask), 0);
    check("mid_rst_rdata", rdata, 0);
    tick();
    mem_rvalid = 1'b0;
    #1;
    check("post_rst_mem_valid", mem_valid, 0);
    check("post_rst_stall", stall, 0);
    valid = 1'b0;

    // non-memop never stalls or requests
    tick();
    valid = 1'b1; is_new = 1'b1;
    ctrl.itype = IT_R; ctrl.is_load = 1'b0; ctrl.funct3 = 3'b000;
    #1;
    check("alu_stall", stall, 0);
    tick();
    is_new = 1'b0;
    #1;
    check("alu_mem_valid", mem_valid, 0);
    valid = 1'b0;

`ifdef MEMUNIT_MISALIGN_CHECK_EN
    do_mis(1'b1, 3'b010, 64'h3002, 64'h0);
`else
    // SH at an odd offset behaves as the aligned halfword
    do_memop(1'b0, 3'b001, 64'h1001, 64'h5A5A_1234, 64'h0, 0, 0, r);
    check("sh_odd_mask", 64'(mem_wmask), 64'h03);
    check("sh_odd_wdata", mem_wdata, 64'h5A5A_1234);
`endif

    // randomized memops against the reference model
    for (int n = 0; n < 60; n++) begin
      ld = 1'($urandom_range(0, 1));
      f3 = ld ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      d  = {$urandom, $urandom};
      md = {$urandom, $urandom};
`ifdef MEMUNIT_MISALIGN_CHECK_EN
      if ((int'(a[2:0]) % nbytes(f3)) != 0) do_mis(ld, f3, a, d);
      else do_memop(ld, f3, a, d, md, $urandom_range(0, 3), $urandom_range(0, 3), r);
`else
      do_memop(ld, f3, a, d, md, $urandom_range(0, 3), $urandom_range(0, 3), r);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
